// File: rtl/hydra_pkg.sv
// Shared definitions for the port write front end: header layout, FSM states
// and the FIFO entry format.
package hydra_pkg;

   localparam int LEN_MSB  = 15;
   localparam int LEN_LSB  = 7;
   localparam int PRI_MSB  = 6;
   localparam int PRI_LSB  = 4;
   localparam int PORT_MSB = 3;
   localparam int PORT_LSB = 0;

   localparam int ENTRY_DATA_W = 16;

   typedef enum logic {
      IN_IDLE,
      IN_RECV
   } in_state_t;

   typedef enum logic [1:0] {
      OUT_IDLE,
      OUT_REQ,
      OUT_XFER,
      OUT_EOP
   } out_state_t;

   typedef struct packed {
      logic                    last;
      logic [ENTRY_DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/port_wr_fifo.sv
// Synchronous FIFO of {last, data} entries with a registered occupancy count
// and a registered margin-based full flag.
module port_wr_fifo #(
   parameter int DATA_WIDTH  = 16,
   parameter int FIFO_DEPTH  = 64,
   parameter int FULL_MARGIN = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic [DATA_WIDTH:0] push_data,
   input  logic                pop,
   output logic [DATA_WIDTH:0] head_data,
   output logic                empty,
   output logic                full,
   output logic                drop
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH - FULL_MARGIN);

   logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [AW:0]         count;
   logic [AW:0]         count_next;
   logic                push_ok;
   logic                pop_ok;

   always_comb begin
      push_ok    = push && (count != DEPTH_C);
      pop_ok     = pop && (count != '0);
      count_next = count;
      if (push_ok && !pop_ok)
         count_next = count + 1'b1;
      else if (!push_ok && pop_ok)
         count_next = count - 1'b1;
   end

   assign head_data = mem[rd_ptr];
   assign empty     = (count == '0);
   assign drop      = push && !push_ok;

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next >= FULL_LVL);
      end
   end

endmodule

// File: rtl/port_wr_frontend.sv
// Per-port write front end: buffers incoming packet words, requests an SRAM
// slot for the head packet and streams it cut-through once granted.
module port_wr_frontend
   import hydra_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int FIFO_DEPTH  = 64,
   parameter int FULL_MARGIN = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_sop,
   input  logic                  wr_vld,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_eop,
   output logic                  full,
   output logic                  xfer_req,
   output logic [3:0]            xfer_dest_port,
   output logic [2:0]            xfer_prior,
   output logic [8:0]            xfer_length,
   input  logic                  xfer_grant,
   output logic                  wr_xfer_data_vld,
   output logic [DATA_WIDTH-1:0] wr_xfer_data,
   output logic                  wr_end_of_packet,
   output logic                  overflow_err,
   output logic                  proto_err
);

   in_state_t   in_state;
   out_state_t  out_state;
   fifo_entry_t push_entry;
   fifo_entry_t head_entry;
   logic        push;
   logic        pop;
   logic        fifo_empty;
   logic        fifo_drop;

   assign push_entry.last = wr_eop;
   assign push_entry.data = wr_data;

   // Outside a packet only a header is accepted; inside one every word is.
   always_comb begin
      push = 1'b0;
      if (wr_vld)
         push = (in_state == IN_RECV) || wr_sop;
   end

   // The header is popped on the grant cycle so data follows the grant directly.
   always_comb begin
      pop = 1'b0;
      if (!fifo_empty)
         pop = ((out_state == OUT_REQ) && xfer_grant) || (out_state == OUT_XFER);
   end

   port_wr_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FULL_MARGIN(FULL_MARGIN)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_entry),
      .pop      (pop),
      .head_data(head_entry),
      .empty    (fifo_empty),
      .full     (full),
      .drop     (fifo_drop)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_state     <= IN_IDLE;
         proto_err    <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         proto_err <= 1'b0;
         if (fifo_drop)
            overflow_err <= 1'b1;
         if (wr_vld) begin
            case (in_state)
               IN_IDLE: begin
                  if (!wr_sop)
                     proto_err <= 1'b1;
                  else if (!wr_eop)
                     in_state <= IN_RECV;
               end
               IN_RECV: begin
                  if (wr_sop)
                     proto_err <= 1'b1;
                  if (wr_eop)
                     in_state <= IN_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_state        <= OUT_IDLE;
         xfer_req         <= 1'b0;
         xfer_dest_port   <= '0;
         xfer_prior       <= '0;
         xfer_length      <= '0;
         wr_xfer_data_vld <= 1'b0;
         wr_xfer_data     <= '0;
         wr_end_of_packet <= 1'b0;
      end else begin
         wr_xfer_data_vld <= 1'b0;
         wr_end_of_packet <= 1'b0;
         case (out_state)
            OUT_IDLE: begin
               if (!fifo_empty) begin
                  xfer_dest_port <= head_entry.data[PORT_MSB:PORT_LSB];
                  xfer_prior     <= head_entry.data[PRI_MSB:PRI_LSB];
                  xfer_length    <= head_entry.data[LEN_MSB:LEN_LSB];
                  xfer_req       <= 1'b1;
                  out_state      <= OUT_REQ;
               end
            end
            OUT_REQ: begin
               if (xfer_grant) begin
                  xfer_req  <= 1'b0;
                  out_state <= OUT_XFER;
                  if (pop) begin
                     wr_xfer_data_vld <= 1'b1;
                     wr_xfer_data     <= head_entry.data;
                     if (head_entry.last)
                        out_state <= OUT_EOP;
                  end
               end
            end
            OUT_XFER: begin
               if (pop) begin
                  wr_xfer_data_vld <= 1'b1;
                  wr_xfer_data     <= head_entry.data;
                  if (head_entry.last)
                     out_state <= OUT_EOP;
               end
            end
            OUT_EOP: begin
               wr_end_of_packet <= 1'b1;
               out_state        <= OUT_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_wr_frontend.sv
// Directed bench for port_wr_frontend with hand-computed expected values.
module tb_port_wr_frontend;

   logic        clk;
   logic        rst;
   logic        wr_sop;
   logic        wr_vld;
   logic [15:0] wr_data;
   logic        wr_eop;
   logic        full;
   logic        xfer_req;
   logic [3:0]  xfer_dest_port;
   logic [2:0]  xfer_prior;
   logic [8:0]  xfer_length;
   logic        xfer_grant;
   logic        wr_xfer_data_vld;
   logic [15:0] wr_xfer_data;
   logic        wr_end_of_packet;
   logic        overflow_err;
   logic        proto_err;

   int checks = 0;
   int errors = 0;
   int eop_cnt = 0;
   int pushed;
   logic [15:0] out_q[$];
   logic [15:0] exp_q[$];

   port_wr_frontend #(
      .DATA_WIDTH (16),
      .FIFO_DEPTH (64),
      .FULL_MARGIN(2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .wr_sop          (wr_sop),
      .wr_vld          (wr_vld),
      .wr_data         (wr_data),
      .wr_eop          (wr_eop),
      .full            (full),
      .xfer_req        (xfer_req),
      .xfer_dest_port  (xfer_dest_port),
      .xfer_prior      (xfer_prior),
      .xfer_length     (xfer_length),
      .xfer_grant      (xfer_grant),
      .wr_xfer_data_vld(wr_xfer_data_vld),
      .wr_xfer_data    (wr_xfer_data),
      .wr_end_of_packet(wr_end_of_packet),
      .overflow_err    (overflow_err),
      .proto_err       (proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (wr_xfer_data_vld)
         out_q.push_back(wr_xfer_data);
      if (wr_end_of_packet)
         eop_cnt++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic sop, input logic eop, input logic [15:0] d);
      wr_vld  = 1'b1;
      wr_sop  = sop;
      wr_eop  = eop;
      wr_data = d;
      tick();
      wr_vld = 1'b0;
      wr_sop = 1'b0;
      wr_eop = 1'b0;
   endtask

   task automatic grant();
      xfer_grant = 1'b1;
      tick();
      xfer_grant = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!xfer_req && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 32'(xfer_req), 32'd1);
   endtask

   task automatic wait_eop(input string tag, input int target);
      int n = 0;
      while (eop_cnt < target && n < 500) begin
         tick();
         n++;
      end
      tick();
      chk({tag, "_eops"}, 32'(eop_cnt), 32'(target));
   endtask

   task automatic chk_fields(input string tag, input int port, input int pri, input int len);
      chk({tag, "_port"}, 32'(xfer_dest_port), 32'(port));
      chk({tag, "_prio"}, 32'(xfer_prior), 32'(pri));
      chk({tag, "_len"},  32'(xfer_length), 32'(len));
   endtask

   task automatic cmp_stream(input string tag);
      chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
   endtask

   task automatic clear();
      out_q.delete();
      exp_q.delete();
      eop_cnt = 0;
   endtask

   task automatic send(input logic sop, input logic eop, input logic [15:0] d);
      drive(sop, eop, d);
      exp_q.push_back(d);
   endtask

   function automatic logic [15:0] word_of(input logic [15:0] hdr, input logic [15:0] base, input int i);
      return (i == 0) ? hdr : base + 16'(i);
   endfunction

   task automatic push_until_full(input logic [15:0] hdr, input logic [15:0] base, input int last_idx);
      while (!full && pushed <= last_idx) begin
         send(pushed == 0, pushed == last_idx, word_of(hdr, base, pushed));
         pushed++;
      end
   endtask

   task automatic push_rest(input logic [15:0] hdr, input logic [15:0] base, input int last_idx);
      int n = 0;
      while (pushed <= last_idx && n < 500) begin
         if (!full) begin
            send(pushed == 0, pushed == last_idx, word_of(hdr, base, pushed));
            pushed++;
         end else begin
            tick();
         end
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      wr_sop = 1'b0;
      wr_vld = 1'b0;
      wr_data = '0;
      wr_eop = 1'b0;
      xfer_grant = 1'b0;
      tick();
      tick();
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_req", 32'(xfer_req), 32'd0);
      chk("rst_vld", 32'(wr_xfer_data_vld), 32'd0);
      chk("rst_eop", 32'(wr_end_of_packet), 32'd0);
      chk("rst_ovf", 32'(overflow_err), 32'd0);
      rst = 1'b0;
      tick();

      // 4-word packet with cycle-exact output timing.
      clear();
      send(1'b1, 1'b0, 16'h0213);
      send(1'b0, 1'b0, 16'hA001);
      send(1'b0, 1'b0, 16'hA002);
      send(1'b0, 1'b1, 16'hA003);
      wait_req("p4");
      chk_fields("p4", 3, 1, 4);
      chk("p4_no_vld_before_grant", 32'(out_q.size()), 32'd0);
      grant();
      chk("p4_vld0", 32'(wr_xfer_data_vld), 32'd1);
      chk("p4_d0", 32'(wr_xfer_data), 32'h0213);
      chk("p4_req_drop", 32'(xfer_req), 32'd0);
      tick();
      chk("p4_d1", 32'(wr_xfer_data), 32'hA001);
      tick();
      chk("p4_d2", 32'(wr_xfer_data), 32'hA002);
      tick();
      chk("p4_d3", 32'(wr_xfer_data), 32'hA003);
      chk("p4_vld3", 32'(wr_xfer_data_vld), 32'd1);
      tick();
      chk("p4_eop_vld", 32'(wr_xfer_data_vld), 32'd0);
      chk("p4_eop", 32'(wr_end_of_packet), 32'd1);
      tick();
      chk("p4_eop_pulse", 32'(wr_end_of_packet), 32'd0);
      cmp_stream("p4");

      // Protocol violations: stray word outside a packet, sop inside a packet.
      clear();
      drive(1'b0, 1'b0, 16'h1234);
      chk("pe_stray", 32'(proto_err), 32'd1);
      tick();
      chk("pe_pulse", 32'(proto_err), 32'd0);
      tick();
      tick();
      chk("pe_dropped", 32'(xfer_req), 32'd0);
      send(1'b1, 1'b0, 16'h0181);
      send(1'b1, 1'b0, 16'h5555);
      chk("pe_mid_sop", 32'(proto_err), 32'd1);
      send(1'b0, 1'b1, 16'h5556);
      wait_req("pe");
      grant();
      wait_eop("pe", 1);
      cmp_stream("pe");

      // Three packets queued while the grant is withheld.
      clear();
      send(1'b1, 1'b0, 16'h0185);
      send(1'b0, 1'b0, 16'hB001);
      send(1'b0, 1'b1, 16'hB002);
      send(1'b1, 1'b0, 16'h0124);
      send(1'b0, 1'b1, 16'hC001);
      send(1'b1, 1'b1, 16'h00F7);
      for (int i = 0; i < 20; i++) begin
         chk("hold_req", 32'(xfer_req), 32'd1);
         chk("hold_port", 32'(xfer_dest_port), 32'd5);
         tick();
      end
      chk("hold_no_vld", 32'(out_q.size()), 32'd0);
      wait_req("b1");
      chk_fields("b1", 5, 0, 3);
      grant();
      wait_req("b2");
      chk_fields("b2", 4, 2, 2);
      grant();
      wait_req("b3");
      chk_fields("b3", 7, 7, 1);
      grant();
      wait_eop("b", 3);
      cmp_stream("b");

      // 70-word packet: full at 62 entries, no overflow, intact delivery.
      clear();
      pushed = 0;
      push_until_full(16'h2339, 16'h3000, 69);
      chk("big_full_at", 32'(pushed), 32'd62);
      chk("big_full", 32'(full), 32'd1);
      wait_req("big");
      chk_fields("big", 9, 3, 70);
      grant();
      push_rest(16'h2339, 16'h3000, 69);
      wait_eop("big", 1);
      chk("big_no_ovf", 32'(overflow_err), 32'd0);
      cmp_stream("big");

      // Forced writes while full: the 65th stored word is dropped.
      clear();
      pushed = 0;
      push_until_full(16'h2101, 16'h4000, 65);
      chk("ovf_full_at", 32'(pushed), 32'd62);
      send(1'b0, 1'b0, 16'h4000 + 16'd62);
      send(1'b0, 1'b0, 16'h4000 + 16'd63);
      chk("ovf_not_yet", 32'(overflow_err), 32'd0);
      drive(1'b0, 1'b0, 16'h4000 + 16'd64);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      pushed = 65;
      wait_req("ovf");
      chk_fields("ovf", 1, 0, 66);
      grant();
      push_rest(16'h2101, 16'h4000, 65);
      wait_eop("ovf", 1);
      chk("ovf_sticky", 32'(overflow_err), 32'd1);
      cmp_stream("ovf");

      // Single-word packet followed immediately by another packet.
      clear();
      send(1'b1, 1'b1, 16'h0086);
      send(1'b1, 1'b0, 16'h0112);
      send(1'b0, 1'b1, 16'hD001);
      wait_req("sw");
      chk_fields("sw", 6, 0, 1);
      grant();
      chk("sw_vld", 32'(wr_xfer_data_vld), 32'd1);
      chk("sw_d", 32'(wr_xfer_data), 32'h0086);
      tick();
      chk("sw_eop", 32'(wr_end_of_packet), 32'd1);
      chk("sw_eop_vld", 32'(wr_xfer_data_vld), 32'd0);
      chk("sw_gap_req", 32'(xfer_req), 32'd0);
      tick();
      chk("sw_next_req", 32'(xfer_req), 32'd1);
      chk_fields("sw2", 2, 1, 2);
      grant();
      wait_eop("sw", 2);
      cmp_stream("sw");

      // Asynchronous reset in the middle of a transfer.
      clear();
      send(1'b1, 1'b0, 16'h0288);
      send(1'b0, 1'b0, 16'hE001);
      send(1'b0, 1'b0, 16'hE002);
      send(1'b0, 1'b0, 16'hE003);
      send(1'b0, 1'b1, 16'hE004);
      wait_req("rx");
      grant();
      tick();
      chk("rx_mid_vld", 32'(wr_xfer_data_vld), 32'd1);
      chk("rx_ovf_before", 32'(overflow_err), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rx_async_vld", 32'(wr_xfer_data_vld), 32'd0);
      chk("rx_async_data", 32'(wr_xfer_data), 32'd0);
      chk("rx_async_ovf", 32'(overflow_err), 32'd0);
      chk("rx_async_port", 32'(xfer_dest_port), 32'd0);
      chk("rx_async_len", 32'(xfer_length), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      clear();
      tick();
      chk("rx_idle_req", 32'(xfer_req), 32'd0);
      send(1'b1, 1'b0, 16'h0193);
      send(1'b0, 1'b0, 16'hF001);
      send(1'b0, 1'b1, 16'hF002);
      wait_req("rx2");
      chk_fields("rx2", 3, 1, 3);
      grant();
      wait_eop("rx2", 1);
      cmp_stream("rx2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
